// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: one host writer with bounded priority, NUM_RD round-robin readers.
// Grants are decided combinationally each cycle; read data returns one cycle after the read ack.
module frame_ram_arbiter #(
    parameter int unsigned ADDR_W       = 9,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned NUM_RD       = 4,
    parameter int unsigned WR_MAX_BURST = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     ram_write,
    output logic [ADDR_W-1:0]        ram_address,
    output logic [DATA_W-1:0]        ram_data_in,
    input  logic [DATA_W-1:0]        ram_data_out
);

    localparam int unsigned PTR_W   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned BURST_W = $clog2(WR_MAX_BURST + 1);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [BURST_W-1:0] r_wr_burst;
    logic [NUM_RD-1:0]  r_rd_valid;
    logic [ADDR_W-1:0]  r_last_addr;

    logic               w_any_rd;
    logic               w_burst_ok;
    logic               w_wr_gnt;
    logic               w_rd_gnt;
    logic               w_rd_found;
    logic [PTR_W-1:0]   w_rd_idx;
    logic [PTR_W:0]     w_scan;
    logic [PTR_W-1:0]   w_rr_next;

    // Arbitration: writer first unless it has used up its burst while readers wait
    always_comb begin
        w_any_rd   = |rd_req;
        w_burst_ok = (r_wr_burst < BURST_W'(WR_MAX_BURST));
        w_wr_gnt   = ~reset & wr_req & (~w_any_rd | w_burst_ok);
        w_rd_found = 1'b0;
        w_rd_idx   = '0;
        w_scan     = '0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            w_scan = (PTR_W+1)'(r_rr_ptr) + (PTR_W+1)'(k);
            if (w_scan >= (PTR_W+1)'(NUM_RD)) begin
                w_scan = w_scan - (PTR_W+1)'(NUM_RD);
            end
            if (!w_rd_found && rd_req[w_scan[PTR_W-1:0]]) begin
                w_rd_found = 1'b1;
                w_rd_idx   = w_scan[PTR_W-1:0];
            end
        end
        w_rd_gnt  = ~reset & ~w_wr_gnt & w_rd_found;
        w_rr_next = (32'(w_rd_idx) == NUM_RD - 1) ? '0 : w_rd_idx + PTR_W'(1);
    end

    // RAM port and acknowledge outputs follow the same-cycle grant
    always_comb begin
        wr_ack      = w_wr_gnt;
        ram_write   = w_wr_gnt;
        ram_data_in = w_wr_gnt ? wr_data : '0;
        rd_ack      = w_rd_gnt ? (NUM_RD'(1) << w_rd_idx) : '0;
        rd_valid    = reset ? '0 : r_rd_valid;
        rd_data     = ram_data_out;
        if (reset) begin
            ram_address = '0;
        end else if (w_wr_gnt) begin
            ram_address = wr_addr;
        end else if (w_rd_gnt) begin
            ram_address = rd_addr[w_rd_idx*ADDR_W +: ADDR_W];
        end else begin
            ram_address = r_last_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_wr_burst  <= '0;
            r_rd_valid  <= '0;
            r_last_addr <= '0;
        end else begin
            r_last_addr <= ram_address;
            r_rd_valid  <= rd_ack;
            if (w_rd_gnt) begin
                r_rr_ptr <= w_rr_next;
            end
            // Burst count only matters while a reader is waiting
            if (w_rd_gnt || !w_any_rd) begin
                r_wr_burst <= '0;
            end else if (w_wr_gnt && w_burst_ok) begin
                r_wr_burst <= r_wr_burst + BURST_W'(1);
            end
        end
    end

endmodule
